// File: rtl/ann_layer_sequencer.sv
// Layer sequencer for a shared single-neuron MAC datapath: walks M neurons of N inputs,
// emitting clear/MAC/bias/write-back strobes with registered outputs, then pulses done.
module ann_layer_sequencer #(
  parameter int N   = 10,
  parameter int M   = 4,
  parameter int LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hidden,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     layer_hidden,
  output logic                     acc_clr,
  output logic                     mac_en,
  output logic [$clog2(N)-1:0]     val_idx,
  output logic [$clog2(N*M)-1:0]   wgt_addr,
  output logic                     bias_en,
  output logic [$clog2(M)-1:0]     neu_idx,
  output logic                     res_we,
  output logic [$clog2(M)-1:0]     res_addr
);

  localparam int IW = $clog2(N);
  localparam int NW = $clog2(M);
  localparam int AW = $clog2(N*M);
  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [IW-1:0] IN_LAST   = IW'(N - 1);
  localparam logic [NW-1:0] NEU_LAST  = NW'(M - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((LAT > 0) ? (LAT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_BIAS  = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   in_q, in_d;
  logic [NW-1:0]   neu_q, neu_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            hid_q, hid_d;
  logic [AW-1:0]   wgt_d;

  // Next-state and counter update; abort outranks every transition outside IDLE.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    neu_d   = neu_q;
    wait_d  = wait_q;
    hid_d   = hid_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      in_d    = '0;
      neu_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            neu_d   = '0;
            hid_d   = hidden;
            state_d = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR: begin
          in_d    = '0;
          state_d = S_MAC;
        end
        S_MAC: begin
          if (in_q == IN_LAST) begin
            state_d = S_BIAS;
          end else begin
            in_d = in_q + IW'(1);
          end
        end
        S_BIAS: begin
          wait_d = '0;
          if (LAT > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_d = S_WRITE;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_WRITE: begin
          if (neu_q == NEU_LAST) begin
            state_d = S_DONE;
          end else begin
            neu_d   = neu_q + NW'(1);
            state_d = S_CLEAR;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          in_d    = '0;
          neu_d   = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Product formed at 32 bits then truncated; N*M-1 always fits in AW bits.
  assign wgt_d = AW'(32'(neu_d) * 32'(N) + 32'(in_d));

  // State, counters and outputs registered together so outputs track the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_q         <= '0;
      neu_q        <= '0;
      wait_q       <= '0;
      hid_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      layer_hidden <= 1'b0;
      acc_clr      <= 1'b0;
      mac_en       <= 1'b0;
      val_idx      <= '0;
      wgt_addr     <= '0;
      bias_en      <= 1'b0;
      neu_idx      <= '0;
      res_we       <= 1'b0;
      res_addr     <= '0;
    end else begin
      state_q      <= state_d;
      in_q         <= in_d;
      neu_q        <= neu_d;
      wait_q       <= wait_d;
      hid_q        <= hid_d;
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_DONE);
      layer_hidden <= hid_d;
      acc_clr      <= (state_d == S_CLEAR);
      mac_en       <= (state_d == S_MAC);
      bias_en      <= (state_d == S_BIAS);
      res_we       <= (state_d == S_WRITE);
      neu_idx      <= neu_d;
      if (state_d == S_MAC) begin
        val_idx  <= in_d;
        wgt_addr <= wgt_d;
      end else begin
        val_idx  <= val_idx;
        wgt_addr <= wgt_addr;
      end
      if (state_d == S_WRITE) begin
        res_addr <= neu_d;
      end else begin
        res_addr <= res_addr;
      end
    end
  end

endmodule

// File: doc/ann_layer_sequencer.md
# ann_layer_sequencer

Sequences the shared single-neuron multiply-accumulate datapath across all neurons of one network layer. It generates operand indices, accumulator clear/enable strobes, the bias-add strobe, and result write-back for M neurons of N inputs each, then pulses `done`. It sits between the network-level control (which issues `start` per layer) and the neuron datapath plus its value, weight, bias and result memories.

## Interface

- `N`, 10: inputs per neuron (N ≥ 2).
- `M`, 4: neurons per layer (M ≥ 2).
- `LAT`, 2: datapath cycles from the bias strobe until the activated result is valid (LAT ≥ 0).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a layer pass; sampled only in IDLE.
- `hidden` input 1: layer type (1 = hidden/ReLU, 0 = output); sampled with `start`.
- `abort` input 1: synchronous cancel; returns to IDLE with no `done`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last neuron's write-back.
- `layer_hidden` output 1: `hidden` latched at start, held until the next accepted start.
- `acc_clr` output 1: clears the datapath accumulator.
- `mac_en` output 1: accumulate value × weight this cycle.
- `val_idx` output $clog2(N): value-memory index.
- `wgt_addr` output $clog2(N*M): weight-memory address, neu_idx*N + val_idx.
- `bias_en` output 1: add bias this cycle.
- `neu_idx` output $clog2(M): current neuron; also the bias-memory address.
- `res_we` output 1: write the datapath result to result memory.
- `res_addr` output $clog2(M): result address, equal to `neu_idx` during write.

## Operation

- States: IDLE, CLEAR, MAC, BIAS, WAIT, WRITE, DONE.
- All outputs are Moore, decoded from registered state and counters.
- Reset: state = IDLE; in_cnt, neu_cnt and wait counter = 0; `layer_hidden` = 0. All outputs are 0 except the index and address outputs, which are also 0.
- IDLE: if `start`=1, set neu_cnt=0, latch `layer_hidden`, and go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): `acc_clr`=1, in_cnt=0, then go to MAC.
- MAC (N cycles): `mac_en`=1, `val_idx`=in_cnt, `wgt_addr`=neu_cnt*N+in_cnt. When in_cnt=N-1, go to BIAS; otherwise in_cnt+1.
- BIAS (1 cycle): `bias_en`=1. Go to WAIT if LAT>0, else to WRITE.
- WAIT (LAT cycles): all strobes low. Wait counter runs 0..LAT-1, then go to WRITE.
- WRITE (1 cycle): `res_we`=1, `res_addr`=neu_cnt.
  - If neu_cnt=M-1, go to DONE.
  - Otherwise neu_cnt+1 and go to CLEAR.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `neu_idx`=neu_cnt in every state. `val_idx` and `wgt_addr` hold their last values outside MAC; consumers must qualify them with `mac_en`.
- `start` while busy: ignored. It is not queued, and `layer_hidden` is unchanged.
- `abort` in any non-IDLE state: next state is IDLE and counters are cleared. No `res_we` or `done` occurs in the following cycles. `abort` has priority over all transitions. `abort` in IDLE has no effect.
- `abort` and `start` together in IDLE: `start` is accepted.
- `rst` mid-pass: immediate return to reset values; no partial write or `done` afterwards.
- Counters never wrap: in_cnt peaks at N-1 and neu_cnt at M-1.
- Address widths for non-power-of-2 N and M are exact $clog2 sizes; the product neu_cnt*N is computed at full width and then truncated to the `wgt_addr` width. This truncation is lossless because N*M-1 fits.

## Timing

- Cycle 0 is the edge that samples `start`. CLEAR is asserted in cycle 1.
- Per neuron: N+LAT+3 cycles (CLEAR 1, MAC N, BIAS 1, WAIT LAT, WRITE 1).
- Neuron k: CLEAR in cycle 1+k(N+LAT+3); WRITE in cycle k(N+LAT+3)+N+LAT+3.
- `done` is in cycle M(N+LAT+3)+1. IDLE (`busy`=0) follows in the next cycle, where a new `start` is accepted.
- `busy` rises in cycle 1 and falls the cycle after `done`.
- Back-to-back layers: gap from `done` to the next CLEAR is at least 2 cycles.

## Test plan

- Reset while idle, then N=10, M=4, LAT=2 with `start`=1 for one cycle → CLEAR in cycle 1; `mac_en` in cycles 2–11 with `val_idx` 0..9 and `wgt_addr` 0..9; `bias_en` in cycle 12; `res_we` in cycle 15 with `res_addr`=0. `done` in cycle 61 only; `busy` high in cycles 1–61.
- Same run → neuron 3 has `wgt_addr` 30..39 in cycles 47–56, `bias_en` in cycle 57, and `res_we` with `res_addr`=3 in cycle 60. Exactly 4 `res_we` pulses and 40 `mac_en` cycles in total.
- `start` pulses in cycles 5 and 30 with `hidden` toggling → no extra `done`, timing unchanged, and `layer_hidden` keeps the value captured in cycle 0.
- `abort` in cycle 20 (neuron 1, MAC) → IDLE in cycle 21 with `busy`=0 and no further `res_we` or `done`. A following `start` restarts at neu_idx=0.
- `rst` asserted asynchronously mid-BIAS → all outputs 0 immediately (before the next edge). After release, the block stays idle until `start`.
- LAT=0, N=2, M=2 → per-neuron period of 5 cycles, with `res_we` in cycles 5 and 10 and `done` in cycle 11.
